shift_seq_ctrl: RTL and testbench
=================================

Name: shift_seq_ctrl

Overview:
Sequential front-end for the 8-bit barrel shifter datapath. It accepts one shift operation per valid/ready handshake and registers the operand and controls. It then applies the log-shifter stages one per cycle; each stage is a per-bit 4:1 select between hold, left, right-fill and rotate. The result is presented on a valid/ready output to the downstream consumer (display/result register).

Parameters:
WIDTH, 8, operand/result width in bits (power of two).
SHW, 3, shift-amount width; equals log2(WIDTH); also the number of stages and SHIFT cycles.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream operation present
in_ready  output  1  block can accept an operation
din  input  WIDTH  operand
shamt  input  SHW  shift amount, 0..WIDTH-1
dir  input  1  0 = left, 1 = right
arith  input  1  1 = arithmetic right (fill with MSB); ignored when dir=0
rot  input  1  rotate request; honoured only with ROTATE_EN
out_valid  output  1  result available
out_ready  input  1  downstream accepts result
dout  output  WIDTH  result
busy  output  1  high in SHIFT or DONE

Behaviour:
- One clock (clk); reset asynchronous, active-low (rst_n). Asserting rst_n=0 immediately forces state IDLE, clears the working register, stage counter and latched controls to 0, and drives out_valid=0, busy=0, dout=0. After release: in_ready=1.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: in_ready=1, busy=0, out_valid=0.
  - Leave IDLE only on in_valid && in_ready at a rising edge. On that edge latch din into the working register; latch shamt, dir, arith and rot; set stage k=0; go to SHIFT.
  - SHIFT: in_ready=0, busy=1. Each cycle: if shamt[k]=1, shift the working register by 2^k in direction dir; else hold it. Increment k. After stage k=SHW-1 go to DONE.
  - DONE: out_valid=1, busy=1, in_ready=0. dout = working register, held stable while out_ready=0. On out_valid && out_ready go to IDLE. There is no same-cycle accept of a new operation.
- Latency: operation accepted at edge N -> out_valid high after edge N+SHW. The latency is fixed, including shamt=0. Throughput is one operation per SHW+2 cycles minimum.
- Fill rules:
  - Left shift: vacated LSBs = 0.
  - Logical right shift (arith=0): vacated MSBs = 0.
  - Arithmetic right shift: vacated MSBs = current MSB, which equals the original din MSB.
- in_valid and input data are ignored outside IDLE. Input changes after the accept edge do not affect the result.
- dout is 0 except in DONE; after the handshake it returns to 0 on the next cycle.
- All arithmetic is unsigned within the SHW-bit counter. No wrap-around beyond SHW stages.

Optional Feature:
ROTATE_EN
- Defined: when the latched rot=1, each active stage rotates instead of shifting. Bits leaving one end re-enter at the other. rot overrides arith.
- Undefined: the rot port remains present but is ignored and treated as 0. No rotate logic is synthesised.

Test Plan:
- Left shift: din=0xB4, shamt=3, dir=0 -> out_valid exactly 3 cycles after the accept edge, dout=0xA0.
- Right shift: din=0xB4, shamt=2, dir=1 -> arith=1 gives dout=0xED; arith=0 gives dout=0x2D. Also din=0xB4, shamt=2, dir=0, arith=1 -> dout=0xD0 (arith ignored on left shift).
- Zero shift: din=0x5A, shamt=0 -> dout=0x5A after the same 3-cycle latency. in_ready stays 0 from accept through DONE.
- Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid=1 and dout stable the whole time, in_ready=0. in_valid pulses during this window are ignored. Releasing out_ready returns to IDLE with in_ready=1 next cycle.
- Reset mid-operation: rst_n=0 in the second SHIFT cycle -> out_valid=0, busy=0, dout=0 without waiting for a clock edge. After release, op din=0x0F, shamt=4, dir=0 -> dout=0xF0.
- Rotate: din=0x81, shamt=1, rot=1 -> with ROTATE_EN, dir=0 gives 0x03 and dir=1 gives 0xC0. Without ROTATE_EN, dir=0 gives 0x02 and dir=1 (arith=0) gives 0x40.

Source files
------------

// File: rtl/shift_seq_ctrl_if.sv
// Handshake and data bundle between the upstream issuer, the sequential
// shifter front-end and the downstream result consumer.
// master = the side that issues operations and consumes results,
// slave  = the shifter block itself.
interface shift_seq_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int SHW   = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] din;
  logic [SHW-1:0]   shamt;
  logic             dir;
  logic             arith;
  logic             rot;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] dout;
  logic             busy;

  modport master (
    output in_valid, din, shamt, dir, arith, rot, out_ready,
    input  in_ready, out_valid, dout, busy
  );

  modport slave (
    input  in_valid, din, shamt, dir, arith, rot, out_ready,
    output in_ready, out_valid, dout, busy
  );
endinterface

// File: rtl/shift_seq_ctrl.sv
// Sequential barrel-shifter front-end: accepts one operation per handshake,
// applies one log-shifter stage per cycle (stage k moves by 2^k when
// shamt[k] is set) and holds the result on a valid/ready output.
// Optional feature macro: ROTATE_EN (rotate instead of shift when rot=1).
module shift_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int SHW   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  shift_seq_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [SHW-1:0] LAST_STAGE = SHW'(SHW - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [SHW-1:0]   stageCnt_q, stageCnt_d;
  logic [SHW-1:0]   shamt_q, shamt_d;
  logic             dir_q, dir_d;
  logic             arith_q, arith_d;

  logic             accept;
  logic             rotEff;
  logic [SHW:0]     stepAmt;
  logic [WIDTH-1:0] leftVal;
  logic [WIDTH-1:0] rightVal;
  logic [WIDTH-1:0] arithVal;
  logic [WIDTH-1:0] stageVal;

  assign accept   = (state_q == IDLE) && bus.in_valid;
  assign stepAmt  = (SHW+1)'(1) << stageCnt_q;
  assign leftVal  = work_q << stepAmt;
  assign rightVal = work_q >> stepAmt;
  assign arithVal = $signed(work_q) >>> stepAmt;

`ifdef ROTATE_EN
  logic             rot_q;
  logic [SHW:0]     backAmt;
  logic [WIDTH-1:0] rotLVal;
  logic [WIDTH-1:0] rotRVal;

  assign backAmt = (SHW+1)'(WIDTH) - stepAmt;
  assign rotLVal = (work_q << stepAmt) | (work_q >> backAmt);
  assign rotRVal = (work_q >> stepAmt) | (work_q << backAmt);
  assign rotEff  = rot_q;

  // Capture the rotate request alongside the other controls on accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rot_q <= 1'b0;
    end else if (accept) begin
      rot_q <= bus.rot;
    end
  end
`else
  logic unusedRot;
  assign unusedRot = bus.rot;
  assign rotEff    = 1'b0;
`endif

  // One stage of the log shifter: hold, left, right-fill or rotate
  always_comb begin
    stageVal = work_q;
    if (shamt_q[stageCnt_q]) begin
`ifdef ROTATE_EN
      if (rotEff) begin
        stageVal = dir_q ? rotRVal : rotLVal;
      end else
`endif
      if (!dir_q) begin
        stageVal = leftVal;
      end else if (arith_q) begin
        stageVal = arithVal;
      end else begin
        stageVal = rightVal;
      end
    end
  end

  // Next-state, datapath update and handshake outputs
  always_comb begin
    state_d       = state_q;
    work_d        = work_q;
    stageCnt_d    = stageCnt_q;
    shamt_d       = shamt_q;
    dir_d         = dir_q;
    arith_d       = arith_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    bus.dout      = '0;
    case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          work_d     = bus.din;
          shamt_d    = bus.shamt;
          dir_d      = bus.dir;
          arith_d    = bus.arith;
          stageCnt_d = '0;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        bus.busy   = 1'b1;
        work_d     = stageVal;
        stageCnt_d = stageCnt_q + 1'b1;
        if (stageCnt_q == LAST_STAGE) begin
          stageCnt_d = '0;
          state_d    = DONE;
        end
      end
      DONE: begin
        bus.out_valid = 1'b1;
        bus.busy      = 1'b1;
        bus.dout      = work_q;
        if (bus.out_ready) begin
          work_d  = '0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      work_q     <= '0;
      stageCnt_q <= '0;
      shamt_q    <= '0;
      dir_q      <= 1'b0;
      arith_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      work_q     <= work_d;
      stageCnt_q <= stageCnt_d;
      shamt_q    <= shamt_d;
      dir_q      <= dir_d;
      arith_q    <= arith_d;
    end
  end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl: directed cases plus randomized
// operations compared against a whole-shift arithmetic model.
// Honours ROTATE_EN the same way the design does.
module tb_shift_seq_ctrl;

  localparam int WIDTH = 8;
  localparam int SHW   = 3;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  shift_seq_ctrl_if #(.WIDTH(WIDTH), .SHW(SHW)) bus ();

  shift_seq_ctrl #(.WIDTH(WIDTH), .SHW(SHW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Count one comparison and report it if it disagrees
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Whole-operation result: the full shamt applied in one step
  function automatic logic [7:0] refShift(input logic [7:0] d, input int s,
                                          input logic dr, input logic ar,
                                          input logic rt);
    int v;
    int r;
    bit doRot;
    v = int'(d);
    doRot = rt;
`ifndef ROTATE_EN
    doRot = 1'b0;
`endif
    if (doRot)
      r = dr ? ((v >> s) | (v << (WIDTH - s))) : ((v << s) | (v >> (WIDTH - s)));
    else if (!dr)
      r = v << s;
    else if (ar && d[7])
      r = (v >> s) | (255 << (WIDTH - s));
    else
      r = v >> s;
    return r[7:0];
  endfunction

  // Randomize every upstream input except the handshake strobe
  task automatic scrambleInputs();
    bus.din   = 8'($urandom);
    bus.shamt = 3'($urandom);
    bus.dir   = 1'($urandom);
    bus.arith = 1'($urandom);
    bus.rot   = 1'($urandom);
  endtask

  // Issue one operation, check latency, backpressure hold and return to idle
  task automatic applyStimulus(input logic [7:0] d, input logic [2:0] s,
                               input logic dr, input logic ar, input logic rt,
                               input int hold, input logic [7:0] expected);
    @(negedge clk);
    bus.din       = d;
    bus.shamt     = s;
    bus.dir       = dr;
    bus.arith     = ar;
    bus.rot       = rt;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    checkOutput("idle_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    scrambleInputs();
    checkOutput("accept_in_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("accept_busy", 32'(bus.busy), 32'd1);
    for (int i = 1; i <= SHW; i++) begin
      @(posedge clk);
      #1;
      bus.in_valid = 1'($urandom);
      scrambleInputs();
      checkOutput("latency_out_valid", 32'(bus.out_valid), (i == SHW) ? 32'd1 : 32'd0);
      checkOutput("shift_in_ready", 32'(bus.in_ready), 32'd0);
    end
    checkOutput("done_dout", 32'(bus.dout), 32'(expected));
    checkOutput("done_busy", 32'(bus.busy), 32'd1);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      bus.in_valid = 1'($urandom);
      scrambleInputs();
      checkOutput("hold_out_valid", 32'(bus.out_valid), 32'd1);
      checkOutput("hold_dout", 32'(bus.dout), 32'(expected));
      checkOutput("hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    checkOutput("release_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("release_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("release_dout", 32'(bus.dout), 32'd0);
    checkOutput("release_busy", 32'(bus.busy), 32'd0);
  endtask

  // Main sequence: reset, directed cases, mid-operation reset, random ops
  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.din       = '0;
    bus.shamt     = '0;
    bus.dir       = 1'b0;
    bus.arith     = 1'b0;
    bus.rot       = 1'b0;
    #12;
    checkOutput("reset_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("reset_busy", 32'(bus.busy), 32'd0);
    checkOutput("reset_dout", 32'(bus.dout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("post_reset_in_ready", 32'(bus.in_ready), 32'd1);

    applyStimulus(8'hB4, 3'd3, 1'b0, 1'b0, 1'b0, 0, 8'hA0);
    applyStimulus(8'hB4, 3'd2, 1'b1, 1'b1, 1'b0, 0, 8'hED);
    applyStimulus(8'hB4, 3'd2, 1'b1, 1'b0, 1'b0, 1, 8'h2D);
    applyStimulus(8'hB4, 3'd2, 1'b0, 1'b1, 1'b0, 0, 8'hD0);
    applyStimulus(8'h5A, 3'd0, 1'b0, 1'b0, 1'b0, 0, 8'h5A);
    applyStimulus(8'hC3, 3'd7, 1'b1, 1'b1, 1'b0, 5, 8'hFF);
    applyStimulus(8'h80, 3'd7, 1'b1, 1'b0, 1'b0, 5, 8'h01);
`ifdef ROTATE_EN
    applyStimulus(8'h81, 3'd1, 1'b0, 1'b0, 1'b1, 0, 8'h03);
    applyStimulus(8'h81, 3'd1, 1'b1, 1'b0, 1'b1, 0, 8'hC0);
    applyStimulus(8'h81, 3'd1, 1'b1, 1'b1, 1'b1, 0, 8'hC0);
`else
    applyStimulus(8'h81, 3'd1, 1'b0, 1'b0, 1'b1, 0, 8'h02);
    applyStimulus(8'h81, 3'd1, 1'b1, 1'b0, 1'b1, 0, 8'h40);
`endif

    @(negedge clk);
    bus.din      = 8'h33;
    bus.shamt    = 3'd7;
    bus.dir      = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("midop_busy_before", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("midop_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("midop_busy", 32'(bus.busy), 32'd0);
    checkOutput("midop_dout", 32'(bus.dout), 32'd0);
    checkOutput("midop_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(8'h0F, 3'd4, 1'b0, 1'b0, 1'b0, 0, 8'hF0);

    for (int n = 0; n < 40; n++) begin
      logic [7:0] d;
      logic [2:0] s;
      logic dr, ar, rt;
      d  = 8'($urandom);
      s  = 3'($urandom);
      dr = 1'($urandom);
      ar = 1'($urandom);
      rt = 1'($urandom);
      applyStimulus(d, s, dr, ar, rt, int'($urandom_range(0, 3)),
                    refShift(d, int'(s), dr, ar, rt));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
